acq_frame_packer: RTL

Parametrised successor to the four-channel pool-test datapath. It snapshots an N-channel, W-bit ADC sample word on a strobe and walks the snapshot out as a self-framed byte stream on a valid/ready byte interface. The byte interface feeds the UART transmitter glue, so the controller no longer sequences word selects by hand. Adds a channel-enable mask, programmable decimation and overrun accounting. Sits between the SIPO/data-buffer stage and the UART TX.

---
 rtl/acq_frame_packer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/acq_frame_packer.sv
// rtl/acq_frame_packer.sv - N-channel ADC sample snapshot packed into a self-framed byte stream
//
// Purpose: on an accepted sample strobe, latch all channel samples and the
// channel mask, then emit a frame on a valid/ready byte interface:
//   8'h00 header, then for each enabled channel (lowest first) a tag byte
//   8'h41+c followed by CHUNKS data bytes {3'b100, 5-bit chunk}, LS chunk first.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   sample_in           NUM_CH packed samples, channel c at [c*SAMPLE_W +: SAMPLE_W]
//   sample_valid        one-cycle sample strobe
//   enable              allow new frames to start
//   ch_enable           per-channel send mask (latched at capture)
//   decim               send one of every decim eligible samples (0 acts as 1)
//   tx_data/tx_valid    registered byte output, held until tx_ready
//   tx_ready            sink accepts the byte this cycle
//   busy                frame in progress
//   frame_done          one-cycle pulse after the final byte is accepted
//   overrun_count       strobes dropped while busy, saturating
module acq_frame_packer #(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH*SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    input  logic                       enable,
    input  logic [NUM_CH-1:0]          ch_enable,
    input  logic [7:0]                 decim,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic                       frame_done,
    output logic [15:0]                overrun_count
);
    localparam int CHUNKS = (SAMPLE_W + 4) / 5;
    localparam int PAD_W  = CHUNKS * 5;

    typedef enum logic [1:0] {IDLE, HEADER, TAG, DATA} state_t;

    state_t                     state, state_n;
    logic [NUM_CH*SAMPLE_W-1:0] snap;
    logic [NUM_CH-1:0]          mask_q;
    logic [3:0]                 ch, ch_n;
    logic [3:0]                 k, k_n;
    logic [7:0]                 decim_cnt, dcnt_n;
    logic [7:0]                 decim_lim;
    logic                       capture, done_n, hs, eligible;
    logic [3:0]                 first_ch, next_ch;
    logic                       has_next;
    logic [SAMPLE_W-1:0]        ch_sample;
    logic [PAD_W-1:0]           padded;
    logic [7:0]                 byte_n;

    assign busy = (state != IDLE);

    // Lowest enabled channel, and lowest enabled channel above the current one.
    // The loop runs downward so the last hit is the lowest index.
    always_comb begin
        first_ch = '0;
        next_ch  = '0;
        has_next = 1'b0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (mask_q[c]) begin
                first_ch = 4'(c);
                if (c > int'(ch)) begin
                    next_ch  = 4'(c);
                    has_next = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_n   = state;
        ch_n      = ch;
        k_n       = k;
        dcnt_n    = decim_cnt;
        capture   = 1'b0;
        done_n    = 1'b0;
        hs        = tx_valid && tx_ready;
        eligible  = sample_valid && enable && (state == IDLE) && (|ch_enable);
        decim_lim = (decim == 8'd0) ? 8'd0 : decim - 8'd1;

        case (state)
            IDLE: begin
                if (eligible) begin
                    if (decim_cnt == decim_lim) begin
                        capture = 1'b1;
                        dcnt_n  = 8'd0;
                        state_n = HEADER;
                    end else begin
                        dcnt_n = decim_cnt + 8'd1;
                    end
                end
            end
            HEADER: begin
                if (hs) begin
                    state_n = TAG;
                    ch_n    = first_ch;
                end
            end
            TAG: begin
                if (hs) begin
                    state_n = DATA;
                    k_n     = 4'd0;
                end
            end
            DATA: begin
                if (hs) begin
                    if (k != 4'(CHUNKS - 1)) begin
                        k_n = k + 4'd1;
                    end else if (has_next) begin
                        state_n = TAG;
                        ch_n    = next_ch;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Output byte is computed for the next state so tx_data is a flop that
        // changes only on the edge that moves the frame forward.
        ch_sample = snap[int'(ch_n)*SAMPLE_W +: SAMPLE_W];
        padded    = PAD_W'(ch_sample);
        case (state_n)
            HEADER:  byte_n = 8'h00;
            TAG:     byte_n = 8'h41 + {4'b0000, ch_n};
            DATA:    byte_n = {3'b100, padded[int'(k_n)*5 +: 5]};
            default: byte_n = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ch            <= '0;
            k             <= '0;
            decim_cnt     <= '0;
            snap          <= '0;
            mask_q        <= '0;
            tx_data       <= '0;
            tx_valid      <= 1'b0;
            frame_done    <= 1'b0;
            overrun_count <= '0;
        end else begin
            state      <= state_n;
            ch         <= ch_n;
            k          <= k_n;
            decim_cnt  <= dcnt_n;
            tx_data    <= byte_n;
            tx_valid   <= (state_n != IDLE);
            frame_done <= done_n;
            if (capture) begin
                snap   <= sample_in;
                mask_q <= ch_enable;
            end
            if (sample_valid && (state != IDLE) && (overrun_count != 16'hFFFF)) begin
                overrun_count <= overrun_count + 16'd1;
            end
        end
    end
endmodule
